// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared sizes and FSM states for the SRAM RW port arbiter
package sram_arb_pkg;

  localparam int DEPTH       = 64;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 114;
  localparam int LANES       = 2;
  localparam int LANE_W      = DATA_W / LANES;
  localparam int RSP_Q_DEPTH = 2;

  // Sweep first (zero-fill), then normal arbitration until the next reset
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - 2-entry synchronous response FIFO, head data always visible
module sram_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [RSP_Q_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Pointer and occupancy tracking; push and pop may coincide
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      assert (!(i_push && !i_pop && (r_count == 2'd2)));
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Data storage needs no reset; occupancy decides what is valid
  always_ff @(posedge i_clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// rtl/sram_rw_port_arbiter.sv - zero-fill, round-robin RW arbitration and read response queue for one SRAM port
module sram_rw_port_arbiter
  import sram_arb_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_w_valid,
  output logic              o_w_ready,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [LANES-1:0]  i_w_mask,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_r_valid,
  output logic              o_r_ready,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_init_done,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_en,
  output logic              o_sram_wmode,
  output logic [LANES-1:0]  o_sram_wmask,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_init_done;
  logic              r_inflight;
  logic              r_rr;

  logic [1:0]        w_q_count;
  logic [DATA_W-1:0] w_q_data;
  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_rd_elig;
  logic              w_run;
  logic              w_contend;
  logic              w_grant_w;
  logic              w_grant_r;

  // A read may only start if its response is guaranteed a queue slot
  assign w_run       = (r_state == ST_RUN) && !i_reset;
  assign o_rsp_valid = !i_reset && (w_q_count != 2'd0);
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  assign w_credit    = {1'b0, w_q_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_elig   = w_credit < 3'd2;

  // Round-robin only applies when both sides could actually be served
  assign w_contend = i_w_valid && i_r_valid && w_rd_elig;
  assign w_grant_w = w_run && i_w_valid && !(w_contend && r_rr);
  assign w_grant_r = w_run && i_r_valid && w_rd_elig && !(w_contend && !r_rr);

  assign o_w_ready   = w_grant_w;
  assign o_r_ready   = w_grant_r;
  assign o_init_done = r_init_done && !i_reset;
  assign o_rsp_data  = o_rsp_valid ? w_q_data : '0;

  // Drive the macro port: sweep write, granted write, granted read, or idle
  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_wmode = 1'b0;
    o_sram_addr  = '0;
    o_sram_wmask = '0;
    o_sram_wdata = '0;
    if (!i_reset && (r_state == ST_INIT)) begin
      o_sram_en    = 1'b1;
      o_sram_wmode = 1'b1;
      o_sram_addr  = r_ptr;
      o_sram_wmask = '1;
    end else if (w_grant_w) begin
      o_sram_en    = 1'b1;
      o_sram_wmode = 1'b1;
      o_sram_addr  = i_w_addr;
      o_sram_wmask = i_w_mask;
      o_sram_wdata = i_w_data;
    end else if (w_grant_r) begin
      o_sram_en    = 1'b1;
      o_sram_addr  = i_r_addr;
    end
  end

  // Sweep FSM, read-in-flight flag and round-robin pointer
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
      r_rr        <= 1'b0;
    end else begin
      r_inflight <= w_grant_r;
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
      if (w_run && w_contend) r_rr <= ~r_rr;
    end
  end

  sram_rsp_fifo #(.W(DATA_W)) u_rsp_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (r_inflight),
    .i_data  (i_sram_rdata),
    .i_pop   (w_pop),
    .o_data  (w_q_data),
    .o_count (w_q_count)
  );

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// tb/tb_sram_rw_port_arbiter.sv - scoreboard bench for the SRAM RW port arbiter
module tb_sram_rw_port_arbiter;
  import sram_arb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              w_valid, w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [LANES-1:0]  w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en, sram_wmode;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] mac_mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clock = ~clock;

  sram_rw_port_arbiter dut (
    .i_clock(clock), .i_reset(reset),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_addr(w_addr), .i_w_mask(w_mask), .i_w_data(w_data),
    .i_r_valid(r_valid), .o_r_ready(r_ready), .i_r_addr(r_addr),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_init_done(init_done),
    .o_sram_addr(sram_addr), .o_sram_en(sram_en), .o_sram_wmode(sram_wmode),
    .o_sram_wmask(sram_wmask), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [LANES-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < DATA_W; b++) if (m[b / LANE_W]) r[b] = new_v[b];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SRAM macro: lane-masked write, 1-cycle read, garbage otherwise
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      mac_mem[sram_addr] <= merge(mac_mem[sram_addr], sram_wdata, sram_wmask);
      sram_rdata <= rnd_data();
    end else if (sram_en) begin
      sram_rdata <= mac_mem[sram_addr];
    end else begin
      sram_rdata <= rnd_data();
    end
  end

  // Reference model + scoreboard: accepted writes update memory, accepted reads queue expected data
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
    end else begin
      check("single_grant", {127'd0, w_ready && r_ready}, 128'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 128'd1, 128'd0);
        else check("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (w_valid && w_ready) ref_mem[w_addr] <= merge(ref_mem[w_addr], w_data, w_mask);
      if (r_valid && r_ready) exp_q.push_back(ref_mem[r_addr]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    w_valid = 0; r_valid = 0;
    repeat (n) step();
  endtask

  // Sweep after reset release: 64 zero writes, no readies, then init_done
  task automatic sweep_check();
    w_valid = 1; r_valid = 1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clock);
      check($sformatf("sweep_addr_%0d", k), sram_addr, k);
      check("sweep_ctl", {sram_en, sram_wmode, sram_wmask}, 4'b1111);
      check("sweep_wdata", sram_wdata, 0);
      check("sweep_quiet", {w_ready, r_ready, init_done, rsp_valid}, 0);
    end
    step();
    w_valid = 0; r_valid = 0;
    @(negedge clock);
    check("init_done", init_done, 1);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] lo_lane;
    int cnt;
    bit seen;
    lo_lane = '0;
    for (int b = 0; b < LANE_W; b++) lo_lane[b] = 1'b1;
    for (int i = 0; i < DEPTH; i++) mac_mem[i] = rnd_data();
    reset = 1; w_valid = 0; r_valid = 0; rsp_ready = 0;
    w_addr = 0; w_mask = 0; w_data = 0; r_addr = 0;
    repeat (3) step();
    @(negedge clock);
    check("reset_outputs", {127'd0, |{w_ready, r_ready, rsp_valid, rsp_data, init_done,
          sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata}}, 0);
    step();
    reset = 0;
    sweep_check();

    // Contended requests alternate W,R,... starting with write after reset
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      w_valid = 1; r_valid = 1;
      w_addr = ADDR_W'($urandom_range(16, 31)); w_mask = 2'($urandom); w_data = rnd_data();
      r_addr = ADDR_W'($urandom_range(16, 31));
      @(negedge clock);
      check($sformatf("contend_%0d", i), {w_ready, r_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    idle(4);

    // Full write then read: data back and 2-cycle response latency
    w_valid = 1; w_addr = 5; w_mask = 2'b11; w_data = '1;
    @(negedge clock); check("w5_ready", w_ready, 1);
    step();
    w_valid = 0; r_valid = 1; r_addr = 5;
    @(negedge clock); check("r5_ready", r_ready, 1);
    step();
    r_valid = 0;
    @(negedge clock); check("lat_t1", rsp_valid, 0);
    step();
    @(negedge clock); check("lat_t2", rsp_valid, 1); check("rd5_data", rsp_data, {DATA_W{1'b1}});
    step();
    idle(2);

    // Lower lane only
    w_valid = 1; w_addr = 9; w_mask = 2'b01; w_data = '1;
    step();
    w_valid = 0; r_valid = 1; r_addr = 9;
    step();
    r_valid = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (rsp_valid) begin seen = 1; check("rd9_lane0", rsp_data, lo_lane); end
      step();
    end
    if (!seen) check("rd9_timeout", 0, 1);
    idle(2);

    // Backpressure: two reads fill the credits, writes still flow
    rsp_ready = 0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      r_valid = 1; r_addr = ADDR_W'($urandom_range(16, 31));
      @(negedge clock); if (r_ready) cnt++;
      step();
    end
    check("bp_reads", cnt, 2);
    for (int i = 0; i < 3; i++) begin
      w_valid = 1; w_addr = ADDR_W'($urandom_range(32, 47)); w_mask = 2'b11; w_data = rnd_data();
      @(negedge clock); check("bp_write_only", {w_ready, r_ready}, 2'b10);
      step();
    end
    w_valid = 0; r_valid = 0; rsp_ready = 1;
    repeat (3) step();
    check("bp_drained", exp_q.size(), 0);
    r_valid = 1; r_addr = 1;
    @(negedge clock); check("bp_resume", r_ready, 1);
    step();
    idle(3);

    // Randomized traffic on a small address window to exercise hazards
    for (int i = 0; i < 400; i++) begin
      w_valid = 1'($urandom); r_valid = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      w_addr = ADDR_W'($urandom_range(0, 7)); w_mask = 2'($urandom); w_data = rnd_data();
      r_addr = ADDR_W'($urandom_range(0, 7));
      step();
    end
    w_valid = 0; r_valid = 0; rsp_ready = 1;
    repeat (6) step();
    check("random_drained", exp_q.size(), 0);

    // Reset with one response queued and one read in flight
    rsp_ready = 0;
    r_valid = 1; r_addr = 3;
    @(negedge clock); check("rst_rd_a", r_ready, 1);
    step();
    r_addr = 4;
    @(negedge clock); check("rst_rd_b", r_ready, 1);
    step();
    r_valid = 0; reset = 1;
    @(negedge clock); check("rst_rsp_valid", rsp_valid, 0);
    step();
    reset = 0; rsp_ready = 1;
    sweep_check();
    idle(10);
    check("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
